reg_bank_sb: RTL and testbench
==============================

Name: reg_bank_sb

Overview:
Parametrised successor to the CPU register bank. Two asynchronous read ports and one write port, with write-address selection by regdst (rd vs. rt field) kept. Adds synchronous clear, an optional hardwired-zero register, optional write-to-read bypass, a per-register pending (scoreboard) bit for multi-cycle loads, and a debug read port. Sits in the decode stage, feeding the ALU operand muxes and the hazard unit.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W registers
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pending; 0 = register 0 is ordinary

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
regwrite  in  1  write enable
regdst  in  1  write-address select: 1 = wa, 0 = ra2
ra1  in  ADDR_W  read address port 1
ra2  in  ADDR_W  read address port 2; also write address when regdst=0
wa  in  ADDR_W  write address when regdst=1
wd  in  DATA_W  write data
rd1  out  DATA_W  read data port 1
rd2  out  DATA_W  read data port 2
busy_set  in  1  mark busy_addr pending (load issued)
busy_addr  in  ADDR_W  register to mark pending
rd1_busy  out  1  register on ra1 is pending
rd2_busy  out  1  register on ra2 is pending
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  debug read data (stored value, never bypassed)

Behaviour:
- waddr = regdst ? wa : ra2. wr_ok = regwrite & ~(ZERO_REG & waddr==0).
- Reset: rising clk with rst_n=0 clears all registers and all pending bits; overrides regwrite and busy_set in that cycle. After that edge rd1=rd2=dbg_data=0, rd1_busy=rd2_busy=0. No state changes without a clk edge (no async reset).
- Write: on rising clk with rst_n=1 and wr_ok, regs[waddr] <= wd. Write to reg 0 with ZERO_REG=1 is dropped silently.
- Reads are combinational, zero latency. rdN = 0 if ZERO_REG & raN==0; else wd if BYPASS & wr_ok & waddr==raN; else regs[raN].
- With BYPASS=0, read of a register being written returns the old value in that cycle and the new value after the edge.
- Scoreboard: pending[] bit per register. On edge with rst_n=1: wr_ok clears pending[waddr]; busy_set sets pending[busy_addr] unless ZERO_REG & busy_addr==0.
- Simultaneous busy_set and wr_ok to the same address: set wins (pending=1 after edge; new load supersedes retiring one). Data is still written.
- rdN_busy = pending[raN] & ~(BYPASS & wr_ok & waddr==raN) — a retiring write this cycle releases the hazard when bypassed. With ZERO_REG=1, raN==0 gives rdN_busy=0.
- regdst=0 write while ra2 addresses the same register: bypass applies to rd2 normally.
- Address arithmetic is plain index, no wrap beyond 2**ADDR_W (full range is valid).
- dbg_data = regs[dbg_addr] (0 for addr 0 when ZERO_REG), unaffected by bypass.

Test Plan:
- Reset clear: preload writes 0xDEADBEEF to r5, busy_set r7; pulse rst_n=0 one edge -> rd1(ra1=5)=0, rd1_busy(ra1=7)=0.
- Zero register: regwrite=1, regdst=1, wa=0, wd=0x1234 -> ra1=0 gives rd1=0 same cycle and after edge; pending never set via busy_addr=0.
- Bypass: BYPASS=1, write wa=3 wd=0xA5A5A5A5 with ra1=3 -> rd1=0xA5A5A5A5 before edge. BYPASS=0 build: rd1=old value until edge, then 0xA5A5A5A5.
- regdst=0 path: ra2=9, regdst=0, wd=0x55 -> after edge dbg_addr=9 reads 0x55; wa ignored (wa=4 unchanged).
- Scoreboard: busy_set r10 -> ra2=10 gives rd2_busy=1 next cycles; write r10 wd=0x77 -> rd2_busy=0 in the write cycle (BYPASS=1), rd2=0x77.
- Set/clear collision: same edge busy_set r12 and write r12 wd=0x99 -> after edge pending r12=1, dbg_data(12)=0x99; reset asserted same edge instead -> r12=0, not pending.

Source files
------------

// File: rtl/reg_bank_sb.sv
// Decode-stage register bank: two async read ports, one write port, a per-register
// pending scoreboard for multi-cycle loads, optional zero register and write bypass.
module reg_bank_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              regwrite,
    input  logic              regdst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic              rd1_busy,
    output logic              rd2_busy,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pending_q;
    logic [DEPTH-1:0]  pending_d;

    logic [ADDR_W-1:0] waddr;
    logic              wr_ok;
    logic              set_ok;
    logic              fwd1;
    logic              fwd2;

    always_comb begin
        waddr  = regdst ? wa : ra2;
        wr_ok  = regwrite & ~(ZERO_REG & (waddr == '0));
        set_ok = busy_set & ~(ZERO_REG & (busy_addr == '0));
        fwd1   = BYPASS & wr_ok & (waddr == ra1);
        fwd2   = BYPASS & wr_ok & (waddr == ra2);
    end

    // The busy_set update comes after the write clear so a new load supersedes a retiring one.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        pending_d = pending_q;
        if (wr_ok) begin
            regs_d[waddr]    = wd;
            pending_d[waddr] = 1'b0;
        end
        if (set_ok) begin
            pending_d[busy_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rd1      = '0;
        rd2      = '0;
        rd1_busy = 1'b0;
        rd2_busy = 1'b0;
        dbg_data = '0;

        if (!(ZERO_REG && (ra1 == '0))) begin
            rd1      = fwd1 ? wd : regs_q[ra1];
            rd1_busy = pending_q[ra1] & ~fwd1;
        end
        if (!(ZERO_REG && (ra2 == '0))) begin
            rd2      = fwd2 ? wd : regs_q[ra2];
            rd2_busy = pending_q[ra2] & ~fwd2;
        end
        if (!(ZERO_REG && (dbg_addr == '0))) begin
            dbg_data = regs_q[dbg_addr];
        end
    end

endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed bench for reg_bank_sb: a vector table against the default build plus
// hand sequences against a BYPASS=0 / ZERO_REG=0 build sharing the same inputs.
module tb_reg_bank_sb;

    logic        clk;
    logic        rst_n;
    logic        regwrite;
    logic        regdst;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        busy_set;
    logic [4:0]  busy_addr;
    logic [4:0]  dbg_addr;

    logic [31:0] a_rd1, a_rd2, a_dbg;
    logic        a_b1, a_b2;
    logic [31:0] b_rd1, b_rd2, b_dbg;
    logic        b_b1, b_b2;

    int errors;
    int checks;

    typedef struct {
        logic        rst_n;
        logic        regwrite;
        logic        regdst;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        busy_set;
        logic [4:0]  busy_addr;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  dbg_addr;
        logic [31:0] exp_rd1;
        logic [31:0] exp_rd2;
        logic        exp_b1;
        logic        exp_b2;
        logic [31:0] exp_dbg;
    } vec_t;

    vec_t vecs[21];

    reg_bank_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .regwrite(regwrite), .regdst(regdst),
        .ra1(ra1), .ra2(ra2), .wa(wa), .wd(wd),
        .rd1(a_rd1), .rd2(a_rd2),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .rd1_busy(a_b1), .rd2_busy(a_b2),
        .dbg_addr(dbg_addr), .dbg_data(a_dbg)
    );

    reg_bank_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .regwrite(regwrite), .regdst(regdst),
        .ra1(ra1), .ra2(ra2), .wa(wa), .wd(wd),
        .rd1(b_rd1), .rd2(b_rd2),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .rd1_busy(b_b1), .rd2_busy(b_b2),
        .dbg_addr(dbg_addr), .dbg_data(b_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 2ns later, well before the next rising edge.
    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        rst_n     = v.rst_n;
        regwrite  = v.regwrite;
        regdst    = v.regdst;
        wa        = v.wa;
        wd        = v.wd;
        busy_set  = v.busy_set;
        busy_addr = v.busy_addr;
        ra1       = v.ra1;
        ra2       = v.ra2;
        dbg_addr  = v.dbg_addr;
        #2;
    endtask

    function automatic vec_t idle(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
        vec_t v;
        v = '{1'b1, 1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 5'd0, r1, r2, d, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        return v;
    endfunction

    task automatic do_reset();
        vec_t v;
        v = idle(5'd0, 5'd0, 5'd0);
        v.rst_n = 1'b0;
        apply_stimulus(v);
        @(posedge clk);
    endtask

    initial begin
        vec_t v;
        errors = 0;
        checks = 0;

        // {rst_n, regwrite, regdst, wa, wd, busy_set, busy_addr, ra1, ra2, dbg, rd1, rd2, b1, b2, dbg}
        vecs[0]  = '{1, 1, 1, 5'd5,  32'hDEADBEEF, 1, 5'd7,  5'd5,  5'd7,  5'd5,  32'hDEADBEEF, 32'h0,        0, 0, 32'h0};
        vecs[1]  = '{1, 0, 1, 5'd0,  32'h0,        0, 5'd0,  5'd5,  5'd7,  5'd5,  32'hDEADBEEF, 32'h0,        0, 1, 32'hDEADBEEF};
        vecs[2]  = '{0, 1, 1, 5'd6,  32'h1,        1, 5'd8,  5'd5,  5'd7,  5'd5,  32'hDEADBEEF, 32'h0,        0, 1, 32'hDEADBEEF};
        vecs[3]  = '{1, 0, 1, 5'd0,  32'h0,        0, 5'd0,  5'd8,  5'd7,  5'd6,  32'h0,        32'h0,        0, 0, 32'h0};
        vecs[4]  = '{1, 1, 1, 5'd0,  32'h1234,     1, 5'd0,  5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        0, 0, 32'h0};
        vecs[5]  = '{1, 0, 1, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        0, 0, 32'h0};
        vecs[6]  = '{1, 1, 1, 5'd3,  32'hA5A5A5A5, 0, 5'd0,  5'd3,  5'd3,  5'd3,  32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 32'h0};
        vecs[7]  = '{1, 1, 0, 5'd4,  32'h55,       0, 5'd0,  5'd4,  5'd9,  5'd3,  32'h0,        32'h55,       0, 0, 32'hA5A5A5A5};
        vecs[8]  = '{1, 0, 1, 5'd0,  32'h0,        0, 5'd0,  5'd4,  5'd9,  5'd9,  32'h0,        32'h55,       0, 0, 32'h55};
        vecs[9]  = '{1, 0, 1, 5'd0,  32'h0,        1, 5'd10, 5'd10, 5'd10, 5'd10, 32'h0,        32'h0,        0, 0, 32'h0};
        vecs[10] = '{1, 0, 1, 5'd0,  32'h0,        0, 5'd0,  5'd10, 5'd10, 5'd10, 32'h0,        32'h0,        1, 1, 32'h0};
        vecs[11] = '{1, 1, 1, 5'd10, 32'h77,       0, 5'd0,  5'd10, 5'd10, 5'd10, 32'h77,       32'h77,       0, 0, 32'h0};
        vecs[12] = '{1, 0, 1, 5'd0,  32'h0,        0, 5'd0,  5'd10, 5'd10, 5'd10, 32'h77,       32'h77,       0, 0, 32'h77};
        vecs[13] = '{1, 1, 1, 5'd12, 32'h99,       1, 5'd12, 5'd12, 5'd12, 5'd12, 32'h99,       32'h99,       0, 0, 32'h0};
        vecs[14] = '{1, 0, 1, 5'd0,  32'h0,        0, 5'd0,  5'd12, 5'd12, 5'd12, 32'h99,       32'h99,       1, 1, 32'h99};
        vecs[15] = '{0, 1, 1, 5'd13, 32'hFF,       1, 5'd13, 5'd12, 5'd13, 5'd12, 32'h99,       32'hFF,       1, 0, 32'h99};
        vecs[16] = '{1, 0, 1, 5'd0,  32'h0,        0, 5'd0,  5'd12, 5'd13, 5'd13, 32'h0,        32'h0,        0, 0, 32'h0};
        vecs[17] = '{1, 1, 1, 5'd31, 32'hCAFEF00D, 1, 5'd31, 5'd31, 5'd30, 5'd31, 32'hCAFEF00D, 32'h0,        0, 0, 32'h0};
        vecs[18] = '{1, 0, 1, 5'd0,  32'h0,        0, 5'd0,  5'd31, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 1, 1, 32'hCAFEF00D};
        vecs[19] = '{1, 1, 1, 5'd31, 32'h1,        0, 5'd0,  5'd0,  5'd1,  5'd31, 32'h0,        32'h0,        0, 0, 32'hCAFEF00D};
        vecs[20] = '{1, 0, 1, 5'd0,  32'h0,        0, 5'd0,  5'd31, 5'd31, 5'd31, 32'h1,        32'h1,        0, 0, 32'h1};

        do_reset();

        // Non-bypassed, ordinary-r0 build: old data until the edge, r0 writable, no busy release.
        v = idle(5'd3, 5'd0, 5'd3);
        apply_stimulus(v);
        check_output("b_reset_rd1", b_rd1, 32'h0);
        check_output("b_reset_dbg", b_dbg, 32'h0);
        v.regwrite = 1'b1; v.wa = 5'd3; v.wd = 32'hA5A5A5A5;
        apply_stimulus(v);
        check_output("b_nobypass_old", b_rd1, 32'h0);
        check_output("a_bypass_new", a_rd1, 32'hA5A5A5A5);
        v = idle(5'd3, 5'd0, 5'd3);
        apply_stimulus(v);
        check_output("b_nobypass_after", b_rd1, 32'hA5A5A5A5);
        v = idle(5'd0, 5'd0, 5'd0);
        v.regwrite = 1'b1; v.wa = 5'd0; v.wd = 32'h1234; v.busy_set = 1'b1; v.busy_addr = 5'd0;
        apply_stimulus(v);
        check_output("b_r0_before", b_rd1, 32'h0);
        v = idle(5'd0, 5'd0, 5'd0);
        apply_stimulus(v);
        check_output("b_r0_written", b_rd1, 32'h1234);
        check_output("b_r0_dbg", b_dbg, 32'h1234);
        check_output("b_r0_busy", {31'b0, b_b2}, 32'h1);
        check_output("a_r0_zero", a_rd1, 32'h0);
        check_output("a_r0_notbusy", {31'b0, a_b2}, 32'h0);
        v.regwrite = 1'b1; v.wa = 5'd0; v.wd = 32'h5;
        apply_stimulus(v);
        check_output("b_r0_busy_no_release", {31'b0, b_b2}, 32'h1);
        check_output("b_r0_old_data", b_rd2, 32'h1234);

        do_reset();
        v = idle(5'd5, 5'd7, 5'd5);
        apply_stimulus(v);
        check_output("a_reset_rd1", a_rd1, 32'h0);
        check_output("a_reset_b2", {31'b0, a_b2}, 32'h0);

        for (int i = 0; i < 21; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("v%0d_rd1", i), a_rd1, vecs[i].exp_rd1);
            check_output($sformatf("v%0d_rd2", i), a_rd2, vecs[i].exp_rd2);
            check_output($sformatf("v%0d_rd1_busy", i), {31'b0, a_b1}, {31'b0, vecs[i].exp_b1});
            check_output($sformatf("v%0d_rd2_busy", i), {31'b0, a_b2}, {31'b0, vecs[i].exp_b2});
            check_output($sformatf("v%0d_dbg", i), a_dbg, vecs[i].exp_dbg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
